// File: rtl/spi_pkg.sv
// Shared frame geometry, register map addresses and the master FSM state type
// for the 40-bit address+data SPI link.
package spi_pkg;

    localparam int SPI_ADDR_BITS  = 8;
    localparam int SPI_DATA_BITS  = 32;
    localparam int SPI_FRAME_BITS = SPI_ADDR_BITS + SPI_DATA_BITS;

    localparam logic [SPI_ADDR_BITS-1:0] FREQ  = 8'h00;
    localparam logic [SPI_ADDR_BITS-1:0] PHASE = 8'h04;
    localparam logic [SPI_ADDR_BITS-1:0] CTRL  = 8'h08;
    localparam logic [SPI_ADDR_BITS-1:0] BAND  = 8'h0C;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spiMasterState_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period divider. Phase starts high whenever enabled and emits
// one-cycle strobes on the last clk cycle of each half-period.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_riseStb,
    output logic o_fallStb,
    output logic o_sampleStb
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_high;
    logic             w_end;

    assign w_end = i_en && (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt  <= '0;
            r_high <= 1'b1;
        end else if (r_cnt == LAST_CNT) begin
            r_cnt  <= '0;
            r_high <= ~r_high;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // The end of a high phase is both the MISO sample point and the fall edge;
    // the end of a low phase is where the next rise (or the frame end) happens.
    assign o_fallStb   = w_end && r_high;
    assign o_sampleStb = w_end && r_high;
    assign o_riseStb   = w_end && !r_high;

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master issuing fixed 40-bit frames (address byte + 32-bit word),
// full duplex, returning the last 32 MISO bits as readback.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic [SPI_ADDR_BITS-1:0] cmdAddr,
    input  logic [SPI_DATA_BITS-1:0] cmdData,
    output logic                     rspValid,
    output logic [SPI_DATA_BITS-1:0] rspData,
    output logic                     busy,
    output logic                     spiSclk,
    output logic                     spiCsN,
    output logic                     spiMosi,
    input  logic                     spiMiso
);

    localparam int PH_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PH_MAX = (PH_SH > CLK_DIV) ? PH_SH : CLK_DIV;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam logic [5:0] LAST_BIT = 6'(SPI_FRAME_BITS - 1);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_master: CLK_DIV must be >= 2");
    end
    if (CS_SETUP < 1) begin : g_bad_cs_setup
        $error("spi_master: CS_SETUP must be >= 1");
    end
    if (CS_HOLD < 1) begin : g_bad_cs_hold
        $error("spi_master: CS_HOLD must be >= 1");
    end

    spiMasterState_t           r_state;
    logic [PH_W-1:0]           r_phase;
    logic [5:0]                r_bit;
    logic [SPI_FRAME_BITS-2:0] r_tx;
    logic [SPI_DATA_BITS-1:0]  r_cap;

    logic w_shift_en;
    logic w_riseStb;
    logic w_fallStb;
    logic w_sampleStb;

    assign w_shift_en = (r_state == SHIFT);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_shift_en),
        .o_riseStb  (w_riseStb),
        .o_fallStb  (w_fallStb),
        .o_sampleStb(w_sampleStb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_bit    <= '0;
            r_tx     <= '0;
            r_cap    <= '0;
            cmdReady <= 1'b0;
            rspValid <= 1'b0;
            rspData  <= '0;
            busy     <= 1'b0;
            spiSclk  <= 1'b0;
            spiCsN   <= 1'b1;
            spiMosi  <= 1'b0;
        end else begin
            rspValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmdReady && cmdValid) begin
                        // MSB goes straight to the pin; r_tx holds the remaining 39 bits.
                        r_tx     <= {cmdAddr[SPI_ADDR_BITS-2:0], cmdData};
                        spiMosi  <= cmdAddr[SPI_ADDR_BITS-1];
                        spiCsN   <= 1'b0;
                        spiSclk  <= 1'b0;
                        cmdReady <= 1'b0;
                        busy     <= 1'b1;
                        r_phase  <= '0;
                        r_bit    <= '0;
                        r_state  <= SETUP;
                    end else begin
                        cmdReady <= 1'b1;
                    end
                end
                SETUP: begin
                    if (r_phase == PH_W'(CS_SETUP - 1)) begin
                        r_phase <= '0;
                        spiSclk <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                SHIFT: begin
                    // Only the trailing 32 samples survive; address-phase bits fall off the top.
                    if (w_sampleStb) begin
                        r_cap <= {r_cap[SPI_DATA_BITS-2:0], spiMiso};
                    end
                    if (w_fallStb) begin
                        spiSclk <= 1'b0;
                        if (r_bit != LAST_BIT) begin
                            spiMosi <= r_tx[SPI_FRAME_BITS-2];
                            r_tx    <= {r_tx[SPI_FRAME_BITS-3:0], 1'b0};
                        end
                    end
                    if (w_riseStb) begin
                        if (r_bit == LAST_BIT) begin
                            spiMosi <= 1'b0;
                            r_phase <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_bit   <= r_bit + 6'd1;
                            spiSclk <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (r_phase == PH_W'(CS_HOLD - 1)) begin
                        spiCsN   <= 1'b1;
                        rspValid <= 1'b1;
                        rspData  <= r_cap;
                        r_phase  <= '0;
                        r_state  <= GAP;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                GAP: begin
                    if (r_phase == PH_W'(CLK_DIV - 1)) begin
                        cmdReady <= 1'b1;
                        busy     <= 1'b0;
                        r_phase  <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: default-parameter instance for function and
// timing, plus a CLK_DIV=2/CS_SETUP=1/CS_HOLD=1 instance for fast-divider timing.
module tb_spi_master;
    import spi_pkg::*;

    typedef struct {
        logic [31:0] rsp;
        logic [39:0] frame;
        int          t_acc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default-parameter instance
    logic        a_rst = 1'b1, a_valid = 1'b0, a_ready, a_rsp_valid, a_busy;
    logic        a_sclk, a_csn, a_mosi, a_miso;
    logic [7:0]  a_addr = '0;
    logic [31:0] a_data = '0, a_rsp_data;
    logic [1:0]  miso_mode = 2'd0;   // 0: tied low, 1: tied high, 2: loopback

    assign a_miso = (miso_mode == 2'd2) ? a_mosi : miso_mode[0];

    spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut_a (
        .clk(clk), .rst(a_rst), .cmdValid(a_valid), .cmdReady(a_ready),
        .cmdAddr(a_addr), .cmdData(a_data), .rspValid(a_rsp_valid),
        .rspData(a_rsp_data), .busy(a_busy), .spiSclk(a_sclk), .spiCsN(a_csn),
        .spiMosi(a_mosi), .spiMiso(a_miso)
    );

    // Fast-divider instance, MISO looped back
    logic        b_rst = 1'b1, b_valid = 1'b0, b_ready, b_rsp_valid, b_busy;
    logic        b_sclk, b_csn, b_mosi;
    logic [7:0]  b_addr = '0;
    logic [31:0] b_data = '0, b_rsp_data;

    spi_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
        .clk(clk), .rst(b_rst), .cmdValid(b_valid), .cmdReady(b_ready),
        .cmdAddr(b_addr), .cmdData(b_data), .rspValid(b_rsp_valid),
        .rspData(b_rsp_data), .busy(b_busy), .spiSclk(b_sclk), .spiCsN(b_csn),
        .spiMosi(b_mosi), .spiMiso(b_mosi)
    );

    exp_t        sb_q[$];
    int          csn_fall_cyc = 0, first_rise_cyc = 0, last_fall_cyc = 0;
    int          rises_a = 0, gap_cnt = 0, last_gap = 0;
    logic [39:0] mosi_sh = '0;

    int          b_fall_cyc = 0, b_low_len = 0, b_run = 0, b_rsp_cyc = 0;
    int          b_hmin = 1000, b_hmax = 0, b_lmin = 1000, b_lmax = 0;
    logic        b_run_ok = 1'b0, b_rsp_seen = 1'b0;
    logic [31:0] b_rsp_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor for instance A: tracks pin activity per frame and
    // compares everything on each rspValid pulse.
    initial begin : mon_a
        logic prev_csn, prev_sclk;
        exp_t e;
        prev_csn  = 1'b1;
        prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_csn && !a_csn) begin
                last_gap     = gap_cnt;
                gap_cnt      = 0;
                csn_fall_cyc = cyc;
                rises_a      = 0;
                mosi_sh      = '0;
            end
            if (a_csn && a_busy) gap_cnt++;
            if (!prev_sclk && a_sclk) begin
                if (rises_a == 0) first_rise_cyc = cyc;
                rises_a++;
                mosi_sh = {mosi_sh[38:0], a_mosi};
            end
            if (prev_sclk && !a_sclk) last_fall_cyc = cyc;
            if (a_rsp_valid) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_rspValid");
                end else begin
                    e = sb_q.pop_front();
                    check("rspData", a_rsp_data, e.rsp);
                    check("mosi_frame", mosi_sh, e.frame);
                    check("rise_count", rises_a, 40);
                    check("rsp_latency", cyc - e.t_acc, 325);
                    check("csn_to_first_rise", first_rise_cyc - csn_fall_cyc, 2);
                    // The final low half-period belongs to the shift; hold follows it.
                    check("hold_after_shift", cyc - last_fall_cyc - 4, 2);
                end
            end
            prev_csn  = a_csn;
            prev_sclk = a_sclk;
        end
    end

    initial begin : mon_b
        logic prev_csn, prev_sclk;
        prev_csn  = 1'b1;
        prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_csn && !b_csn) begin
                b_fall_cyc = cyc;
                b_run_ok   = 1'b0;
            end
            if (!prev_csn && b_csn) b_low_len = cyc - b_fall_cyc;
            if (!b_csn) begin
                if (b_sclk != prev_sclk) begin
                    if (b_run_ok) begin
                        if (prev_sclk) begin
                            if (b_run < b_hmin) b_hmin = b_run;
                            if (b_run > b_hmax) b_hmax = b_run;
                        end else begin
                            if (b_run < b_lmin) b_lmin = b_run;
                            if (b_run > b_lmax) b_lmax = b_run;
                        end
                    end
                    b_run_ok = 1'b1;
                    b_run    = 1;
                end else begin
                    b_run++;
                end
            end
            if (b_rsp_valid) begin
                b_rsp_seen = 1'b1;
                b_rsp_cyc  = cyc;
                b_rsp_val  = b_rsp_data;
            end
            prev_csn  = b_csn;
            prev_sclk = b_sclk;
        end
    end

    task automatic issue(input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp_rsp,
                         input bit push, output int t);
        int n;
        exp_t e;
        tick();
        a_addr  = a;
        a_data  = d;
        a_valid = 1'b1;
        n = 0;
        while (!a_ready && n < 1000) begin
            tick();
            n++;
        end
        if (!a_ready) fail_now("accept_timeout");
        t = cyc;
        if (push) begin
            e.rsp   = exp_rsp;
            e.frame = {a, d};
            e.t_acc = t;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        tick();
        n = 0;
        while (!a_ready && n < 1000) begin
            tick();
            n++;
        end
        if (!a_ready) fail_now("idle_timeout");
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t1, t2, n;
        repeat (3) tick();
        check("rst_cmdReady", a_ready, 0);
        check("rst_rspValid", a_rsp_valid, 0);
        check("rst_rspData", a_rsp_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_spiSclk", a_sclk, 0);
        check("rst_spiCsN", a_csn, 1);
        check("rst_spiMosi", a_mosi, 0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        tick();
        check("ready_after_rst", a_ready, 1);

        // Write FREQ with MISO tied low
        miso_mode = 2'd0;
        issue(FREQ, 32'h1234_5678, 32'h0000_0000, 1'b1, t1);
        tick();
        a_valid = 1'b0;
        check("busy_after_accept", a_busy, 1);
        wait_idle();

        // Loopback
        miso_mode = 2'd2;
        issue(BAND, 32'hA5A5_00FF, 32'hA5A5_00FF, 1'b1, t1);
        tick();
        a_valid = 1'b0;
        wait_idle();

        // MISO tied high
        miso_mode = 2'd1;
        issue(CTRL, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, t1);
        tick();
        a_valid = 1'b0;
        wait_idle();

        // Two commands with cmdValid held; inputs change while the first is in flight
        miso_mode = 2'd2;
        issue(PHASE, 32'h1122_3344, 32'h1122_3344, 1'b1, t1);
        issue(FREQ, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1, t2);
        check("b2b_accept_gap", t2 - t1, 329);
        tick();
        a_valid = 1'b0;
        check("b2b_csn_high_busy", last_gap, 4);
        wait_idle();

        // A cmdValid pulse mid-frame must be ignored
        miso_mode = 2'd1;
        issue(CTRL, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, t1);
        tick();
        a_valid = 1'b0;
        while (cyc < t1 + 100) tick();
        check("rspData_holds", a_rsp_data, 32'hCAFE_BABE);
        check("ready_low_midframe", a_ready, 0);
        a_addr  = FREQ;
        a_data  = 32'h0BAD_0BAD;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        wait_idle();
        tick();
        tick();
        check("no_queued_busy", a_busy, 0);
        check("no_queued_csn", a_csn, 1);

        // Reset at the 20th SCLK rise; no response is expected for this frame
        miso_mode = 2'd2;
        issue(BAND, 32'h1357_9BDF, 32'h0, 1'b0, t1);
        tick();
        a_valid = 1'b0;
        n = 0;
        while (rises_a < 20 && n < 1000) begin
            tick();
            n++;
        end
        if (rises_a < 20) fail_now("rise20_timeout");
        check("rspData_before_rst", a_rsp_data, 32'hFFFF_FFFF);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        check("midrst_csn", a_csn, 1);
        check("midrst_sclk", a_sclk, 0);
        check("midrst_mosi", a_mosi, 0);
        check("midrst_rspData", a_rsp_data, 0);
        tick();
        check("midrst_ready", a_ready, 1);

        // Clean frame after reset
        issue(BAND, 32'h5A5A_F00F, 32'h5A5A_F00F, 1'b1, t1);
        tick();
        a_valid = 1'b0;
        wait_idle();
        if (sb_q.size() != 0) fail_now("missing_rspValid");

        // Fast divider instance
        tick();
        b_addr  = BAND;
        b_data  = 32'h3C3C_C3C3;
        b_valid = 1'b1;
        n = 0;
        while (!b_ready && n < 1000) begin
            tick();
            n++;
        end
        if (!b_ready) fail_now("b_accept_timeout");
        t2 = cyc;
        tick();
        b_valid = 1'b0;
        n = 0;
        while (!b_rsp_seen && n < 1000) begin
            tick();
            n++;
        end
        if (!b_rsp_seen) fail_now("b_rsp_timeout");
        check("b_rspData", b_rsp_val, 32'h3C3C_C3C3);
        check("b_rsp_latency", b_rsp_cyc - t2, 163);
        check("b_csn_low_len", b_low_len, 162);
        check("b_high_min", b_hmin, 2);
        check("b_high_max", b_hmax, 2);
        check("b_low_min", b_lmin, 2);
        check("b_low_max", b_lmax, 2);

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
